// File: rtl/root_process_arbiter.sv
// Round-robin arbiter sharing one (A - 3B - TEMP) datapath among NREQ requesters.
// One grant per transaction: IDLE (grant) -> EXEC (evaluate) -> RESP (hold until taken).
module root_process_arbiter #(
   parameter int NREQ  = 4,
   parameter int NBITS = 8,
   parameter int TEMP  = 21,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NREQ-1:0]       REQ_VALID,
   output logic [NREQ-1:0]       REQ_READY,
   input  logic [NREQ*NBITS-1:0] REQ_A,
   input  logic [NREQ*NBITS-1:0] REQ_B,
   output logic                  RSP_VALID,
   input  logic                  RSP_READY,
   output logic [IDW-1:0]        RSP_ID,
   output logic [NBITS-1:0]      RSP_DATA,
   output logic [15:0]           DONE_COUNT
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [NBITS-1:0] TEMP_N = NBITS'(TEMP);

   state_t           state;
   state_t           state_next;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   win;
   logic             found;
   logic             grant;
   logic             hs;
   logic [NREQ-1:0]  ready;
   logic [NBITS-1:0] a_r;
   logic [NBITS-1:0] b_r;
   logic [NBITS-1:0] b3;
   logic [IDW-1:0]   id_r;
   logic [IDW-1:0]   ptr_next;
   logic             rsp_valid;
   logic [IDW-1:0]   rsp_id;
   logic [NBITS-1:0] rsp_data;
   logic [15:0]      done_count;
   logic [15:0]      done_next;

   // Search starts at ptr and wraps, so the last-served requester goes last.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && REQ_VALID[(int'(ptr) + k) % NREQ]) begin
            found = 1'b1;
            win   = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (found) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (RSP_READY) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready = '0;
      grant = (state == IDLE) && found && !RST;
      hs    = (state == RESP) && RSP_READY;
      if (grant) ready[win] = 1'b1;
   end

   assign b3        = b_r + b_r + b_r;
   assign ptr_next  = (id_r == IDW'(NREQ - 1)) ? '0 : id_r + 1'b1;
   assign done_next = done_count + {15'd0, hs};

   always_ff @(posedge CLK) begin
      if (RST) begin
         a_r       <= '0;
         b_r       <= '0;
         id_r      <= '0;
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         if (grant) begin
            a_r  <= REQ_A[int'(win)*NBITS +: NBITS];
            b_r  <= REQ_B[int'(win)*NBITS +: NBITS];
            id_r <= win;
         end
         if (state == EXEC) begin
            rsp_data  <= a_r - b3 - TEMP_N;
            rsp_id    <= id_r;
            rsp_valid <= 1'b1;
         end
         if (hs) begin
            rsp_valid <= 1'b0;
            ptr       <= ptr_next;
         end
      end
   end

   // Written every cycle so the counter simply follows done_next.
   always_ff @(posedge CLK) begin
      if (RST) done_count <= '0;
      else     done_count <= done_next;
   end

   assign REQ_READY  = ready;
   assign RSP_VALID  = rsp_valid;
   assign RSP_ID     = rsp_id;
   assign RSP_DATA   = rsp_data;
   assign DONE_COUNT = done_count;

endmodule

// File: tb/tb_root_process_arbiter.sv
// Scoreboard bench for root_process_arbiter: grants push expected results,
// responses pop and compare; directed scenarios check timing and corner cases.
module tb_root_process_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_data;
   logic [15:0] done_count;

   typedef struct {
      int         id;
      logic [7:0] data;
      int         gcyc;
   } exp_t;

   exp_t        sb[$];
   int          gseq[$];
   int          gcq[$];
   int          n_chk;
   int          n_fail;
   int          cyc;
   int          mptr;
   logic [15:0] mdone;
   logic        prev_v;

   root_process_arbiter dut (
      .CLK        (clk),
      .RST        (rst),
      .REQ_VALID  (req_valid),
      .REQ_READY  (req_ready),
      .REQ_A      (req_a),
      .REQ_B      (req_b),
      .RSP_VALID  (rsp_valid),
      .RSP_READY  (rsp_ready),
      .RSP_ID     (rsp_id),
      .RSP_DATA   (rsp_data),
      .DONE_COUNT (done_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_data(input logic [7:0] a,
                                             input logic [7:0] b);
      logic [7:0] three_b;
      three_b = 8'((3 * int'(b)) % 256);
      return 8'((int'(a) - int'(three_b) - 21 + 1024) % 256);
   endfunction

   function automatic int rr_pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic monitor();
      int   w;
      exp_t e;
      forever begin
         @(negedge clk);
         chk("done_count", 32'(done_count), 32'(mdone));
         if (rst) begin
            chk("ready_in_rst", 32'(req_ready), 0);
            sb.delete();
            mptr   = 0;
            mdone  = '0;
            prev_v = 1'b0;
         end else begin
            if (req_ready != 4'd0) begin
               w = rr_pick(req_valid, mptr);
               chk("grant", 32'(req_ready), (w < 0) ? 0 : (1 << w));
               if (w >= 0) begin
                  e.id   = w;
                  e.data = model_data(req_a[w*8 +: 8], req_b[w*8 +: 8]);
                  e.gcyc = cyc;
                  sb.push_back(e);
                  gseq.push_back(w);
                  gcq.push_back(cyc);
               end
            end
            if (rsp_valid && !prev_v) begin
               if (sb.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
               else chk("latency", 32'(cyc - sb[0].gcyc), 2);
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
               e = sb.pop_front();
               chk("sb_id", 32'(rsp_id), 32'(e.id));
               chk("sb_data", 32'(rsp_data), 32'(e.data));
               mptr  = (e.id + 1) % 4;
               mdone = mdone + 16'd1;
            end
            prev_v = rsp_valid;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rsp_valid) break;
         step();
      end
      chk("rsp_wait", 32'(rsp_valid), 1);
   endtask

   // Called at posedge+1 with the FSM idle; returns at posedge+1 after the handshake.
   task automatic one_txn(input int idx, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp);
      req_a[idx*8 +: 8] = a;
      req_b[idx*8 +: 8] = b;
      req_valid[idx]    = 1'b1;
      rsp_ready         = 1'b1;
      @(negedge clk);
      chk("txn_ready", 32'(req_ready), 32'(1 << idx));
      step();
      req_valid[idx] = 1'b0;
      wait_rsp();
      chk("txn_id", 32'(rsp_id), 32'(idx));
      chk("txn_data", 32'(rsp_data), 32'(exp));
      step();
   endtask

   initial begin
      int         start;
      logic [15:0] d0;
      n_chk     = 0;
      n_fail    = 0;
      mptr      = 0;
      mdone     = '0;
      prev_v    = 1'b0;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      fork
         monitor();
      join_none

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 32'(rsp_valid), 0);
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_data", 32'(rsp_data), 0);
      chk("rst_done", 32'(done_count), 0);
      chk("rst_ready", 32'(req_ready), 0);
      step();

      // single request from requester 2
      one_txn(2, 8'd100, 8'd10, 8'd49);
      @(negedge clk);
      chk("single_done", 32'(done_count), 1);
      step();

      // wrap-around arithmetic
      one_txn(0, 8'd0, 8'd0, 8'd235);
      one_txn(1, 8'd10, 8'd100, 8'd201);
      one_txn(3, 8'd255, 8'd255, 8'd237);

      // fairness: all valid, pointer is back at 0
      start = gseq.size();
      for (int i = 0; i < 4; i++) begin
         req_a[i*8 +: 8] = 8'(5 + 20 * i);
         req_b[i*8 +: 8] = 8'(i + 1);
      end
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      repeat (18) step();
      req_valid = '0;
      repeat (6) step();
      chk("fair_n", 32'(gseq.size() - start), 6);
      for (int k = 0; k < 6; k++) begin
         if (start + k < gseq.size()) begin
            chk("fair_id", 32'(gseq[start+k]), 32'(k % 4));
            if (k > 0)
               chk("fair_gap", 32'(gcq[start+k] - gcq[start+k-1]), 3);
         end
      end

      // backpressure, with requester 2 waiting behind it
      rsp_ready = 1'b0;
      req_a[15:8] = 8'd50;
      req_b[15:8] = 8'd7;
      req_valid[1] = 1'b1;
      @(negedge clk);
      chk("bp_grant", 32'(req_ready), 32'h2);
      step();
      req_valid[1] = 1'b0;
      req_a[23:16] = 8'd3;
      req_b[23:16] = 8'd1;
      req_valid[2] = 1'b1;
      wait_rsp();
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         chk("bp_valid", 32'(rsp_valid), 1);
         chk("bp_id", 32'(rsp_id), 1);
         chk("bp_data", 32'(rsp_data), 8);
         chk("bp_ready", 32'(req_ready), 0);
         step();
      end
      d0 = mdone;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_hold_data", 32'(rsp_data), 8);
      step();
      @(negedge clk);
      chk("bp_idle_grant", 32'(req_ready), 32'h4);
      chk("bp_done", 32'(done_count), 32'(d0 + 16'd1));
      step();
      req_valid[2] = 1'b0;
      wait_rsp();
      chk("bp2_id", 32'(rsp_id), 2);
      chk("bp2_data", 32'(rsp_data), 235);
      step();

      // reset during EXEC
      req_a[15:8] = 8'd9;
      req_b[15:8] = 8'd9;
      req_valid[1] = 1'b1;
      @(negedge clk);
      chk("rx_grant", 32'(req_ready), 32'h2);
      step();
      req_valid[1] = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rx_valid", 32'(rsp_valid), 0);
      chk("rx_data", 32'(rsp_data), 0);
      chk("rx_done", 32'(done_count), 0);
      step();

      // reset during RESP
      rsp_ready = 1'b0;
      req_a[31:24] = 8'd9;
      req_b[31:24] = 8'd9;
      req_valid[3] = 1'b1;
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), 32'h8);
      step();
      req_valid[3] = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("rr_in_resp", 32'(rsp_valid), 1);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rr_valid", 32'(rsp_valid), 0);
      chk("rr_id", 32'(rsp_id), 0);
      chk("rr_data", 32'(rsp_data), 0);
      chk("rr_done", 32'(done_count), 0);
      step();

      // pointer back at 0: requester 0 wins over 3, then 3
      rsp_ready = 1'b1;
      req_a[7:0] = 8'd40;
      req_b[7:0] = 8'd2;
      req_valid = 4'b1001;
      @(negedge clk);
      chk("ptr0_grant", 32'(req_ready), 32'h1);
      step();
      req_valid[0] = 1'b0;
      wait_rsp();
      chk("ptr0_id", 32'(rsp_id), 0);
      chk("ptr0_data", 32'(rsp_data), 13);
      step();
      @(negedge clk);
      chk("ptr3_grant", 32'(req_ready), 32'h8);
      step();
      req_valid[3] = 1'b0;
      wait_rsp();
      chk("ptr3_id", 32'(rsp_id), 3);
      step();

      // counter wrap from 0xFFFF
      force dut.done_count = 16'hFFFF;
      mdone = 16'hFFFF;
      step();
      release dut.done_count;
      one_txn(2, 8'd1, 8'd0, 8'd236);
      @(negedge clk);
      chk("done_wrap", 32'(done_count), 0);
      step();

      repeat (3) step();
      chk("sb_empty", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
